cipher_dispatch: RTL

- Sits directly downstream of the FIFO message/key assembler.
- Captures each completed {msg, key} pair on the rising edge of the assembler's ready level and buffers up to 2 pairs.
- Launches one AES-128 core operation per pair, captures the 128-bit ciphertext, and serializes it into four 32-bit words on an output FIFO write port under full backpressure.

---
 rtl/cipher_dispatch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cipher_dispatch.sv
// Buffers {msg, key} pairs from the assembler, runs each through the AES core and
// writes the ciphertext as four 32-bit words. Optional watchdog: define AES_TIMEOUT_EN.
module cipher_dispatch #(
  parameter int DROP_CNT_W  = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [127:0]          msg,
  input  logic [127:0]          key,
  input  logic                  ready,
  output logic                  aes_start,
  output logic [127:0]          aes_pt,
  output logic [127:0]          aes_key,
  input  logic                  aes_done,
  input  logic [127:0]          aes_ct,
  output logic [31:0]           fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT, SER} state_t;

  state_t         state, state_nxt;
  logic           ready_d1;
  logic [1:0]     count;
  logic           wr_ptr, rd_ptr;
  logic [127:0]   q_msg [2];
  logic [127:0]   q_key [2];
  logic [127:0]   ct_reg;
  logic [1:0]     idx;
  logic           push, pop, push_ok;

  assign push    = ready & ~ready_d1;
  assign pop     = (state == IDLE) && (count != 2'd0);
  // A pop in the same cycle frees the slot the push lands in
  assign push_ok = push && ((count != 2'd2) || pop);
  assign busy    = (state != IDLE) || (count != 2'd0);

`ifdef AES_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  logic [TIMER_W-1:0] timer;
  logic               timeout_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_wr_en = 1'b0;
    fifo_din   = 32'd0;
`ifdef AES_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: if (count != 2'd0) state_nxt = WAIT;
      WAIT: begin
        // aes_done takes priority over an expiring watchdog
        if (aes_done) state_nxt = SER;
`ifdef AES_TIMEOUT_EN
        else if (timer == TIMER_W'(TIMEOUT_CYC - 1)) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      SER: begin
        fifo_wr_en = ~fifo_full;
        case (idx)
          2'd0:    fifo_din = ct_reg[127:96];
          2'd1:    fifo_din = ct_reg[95:64];
          2'd2:    fifo_din = ct_reg[63:32];
          default: fifo_din = ct_reg[31:0];
        endcase
        if (!fifo_full && idx == 2'd3) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_d1  <= 1'b0;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      aes_start <= 1'b0;
      aes_pt    <= 128'd0;
      aes_key   <= 128'd0;
      ct_reg    <= 128'd0;
      idx       <= 2'd0;
      drop_cnt  <= '0;
    end else begin
      ready_d1  <= ready;
      aes_start <= pop;
      count     <= count + {1'b0, push_ok} - {1'b0, pop};
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop) begin
        aes_pt  <= q_msg[rd_ptr];
        aes_key <= q_key[rd_ptr];
        rd_ptr  <= ~rd_ptr;
      end
      if (push && !push_ok && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      if (state == WAIT && aes_done) begin
        ct_reg <= aes_ct;
        idx    <= 2'd0;
      end else if (fifo_wr_en) begin
        idx <= idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_msg[wr_ptr] <= msg;
      q_key[wr_ptr] <= key;
    end
  end

`ifdef AES_TIMEOUT_EN
  // Timer restarts on every launch, so it always measures the current WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (pop)                 timer <= '0;
      else if (state == WAIT)  timer <= timer + TIMER_W'(1);
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
